// File: rtl/bitonic_cas_sequencer.sv
// Serial bitonic sorter: streams in N (key, arrival index) pairs, walks the
// bitonic compare schedule through one registered compare-and-swap stage,
// then streams the sorted pairs out one per accepted beat.
module bitonic_cas_sequencer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned N_INPUTS    = 8,
    parameter int unsigned INDEX_WIDTH = $clog2(N_INPUTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sort_dir,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   busy
);

    localparam int unsigned LOG2N = $clog2(N_INPUTS);
    localparam int unsigned PW    = (LOG2N > 1) ? LOG2N - 1 : 1;

    localparam logic [INDEX_WIDTH-1:0] ONE_IDX    = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX   = INDEX_WIDTH'(N_INPUTS - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_STAGE = INDEX_WIDTH'(LOG2N - 1);
    localparam logic [PW-1:0]          ONE_PAIR   = PW'(1);
    localparam logic [PW-1:0]          LAST_PAIR  = PW'(N_INPUTS / 2 - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;      // load position / drain position
    logic                   dir_q, dir_d;
    logic [INDEX_WIDTH-1:0] stage_q, stage_d;  // k = 2 << stage
    logic [INDEX_WIDTH-1:0] step_q, step_d;    // j = 1 << step
    logic [PW-1:0]          pair_q, pair_d;    // which of the N/2 pairs in this step
    logic                   cas_en_q, cas_en_d;
    logic [DATA_WIDTH-1:0]  cas_o1_q, cas_o1_d, cas_o2_q, cas_o2_d;
    logic [INDEX_WIDTH-1:0] cas_od1_q, cas_od1_d, cas_od2_q, cas_od2_d;
    logic [DATA_WIDTH-1:0]  buf_data_q [N_INPUTS];
    logic [DATA_WIDTH-1:0]  buf_data_d [N_INPUTS];
    logic [INDEX_WIDTH-1:0] buf_idx_q  [N_INPUTS];
    logic [INDEX_WIDTH-1:0] buf_idx_d  [N_INPUTS];
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic                   busy_q, busy_d;

    logic [INDEX_WIDTH-1:0] pair_x_c, step_bit_c, low_mask_c, lo_c, hi_c, kshift_c, nxt_c;
    logic                   up_c, swap_c;

    assign in_ready  = rst_n && (state_q == ST_LOAD);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;

    // Operand addresses and CAS decision for the current pair (lo has bit j clear).
    always_comb begin
        pair_x_c   = INDEX_WIDTH'(pair_q);
        step_bit_c = ONE_IDX << step_q;
        low_mask_c = step_bit_c - ONE_IDX;
        lo_c       = ((pair_x_c & ~low_mask_c) << 1) | (pair_x_c & low_mask_c);
        hi_c       = lo_c | step_bit_c;
        kshift_c   = (lo_c >> stage_q) >> 1;
        up_c       = kshift_c[0] ? !dir_q : dir_q;
        swap_c     = up_c ? (buf_data_q[lo_c] >  buf_data_q[hi_c])
                          : (buf_data_q[lo_c] <= buf_data_q[hi_c]);
        nxt_c      = cnt_q + ONE_IDX;
    end

    // Next-state, buffer update, CAS stage and output register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        stage_d     = stage_q;
        step_d      = step_q;
        pair_d      = pair_q;
        cas_en_d    = 1'b0;
        cas_o1_d    = cas_o1_q;
        cas_o2_d    = cas_o2_q;
        cas_od1_d   = cas_od1_q;
        cas_od2_d   = cas_od2_q;
        buf_data_d  = buf_data_q;
        buf_idx_d   = buf_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        busy_d      = busy_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    buf_data_d[cnt_q] = in_data;
                    buf_idx_d[cnt_q]  = cnt_q;
                    if (cnt_q == '0) begin
                        dir_d = sort_dir;
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        stage_d = '0;
                        step_d  = '0;
                        pair_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ST_SORT;
                    end else begin
                        cnt_d = nxt_c;
                    end
                end
            end

            ST_SORT: begin
                if (!cas_en_q) begin
                    // Issue: register the compare-and-swap result.
                    cas_en_d  = 1'b1;
                    cas_o1_d  = swap_c ? buf_data_q[hi_c] : buf_data_q[lo_c];
                    cas_od1_d = swap_c ? buf_idx_q[hi_c]  : buf_idx_q[lo_c];
                    cas_o2_d  = swap_c ? buf_data_q[lo_c] : buf_data_q[hi_c];
                    cas_od2_d = swap_c ? buf_idx_q[lo_c]  : buf_idx_q[hi_c];
                end else begin
                    // Writeback, then step to the next comparison in the schedule.
                    buf_data_d[lo_c] = cas_o1_q;
                    buf_idx_d[lo_c]  = cas_od1_q;
                    buf_data_d[hi_c] = cas_o2_q;
                    buf_idx_d[hi_c]  = cas_od2_q;
                    if (pair_q != LAST_PAIR) begin
                        pair_d = pair_q + ONE_PAIR;
                    end else begin
                        pair_d = '0;
                        if (step_q != '0) begin
                            step_d = step_q - ONE_IDX;
                        end else if (stage_q != LAST_STAGE) begin
                            stage_d = stage_q + ONE_IDX;
                            step_d  = stage_q + ONE_IDX;
                        end else begin
                            cnt_d       = '0;
                            out_valid_d = 1'b1;
                            out_data_d  = buf_data_d[0];
                            out_index_d = buf_idx_d[0];
                            state_d     = ST_DRAIN;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_index_d = '0;
                        busy_d      = 1'b0;
                        state_d     = ST_LOAD;
                    end else begin
                        cnt_d       = nxt_c;
                        out_data_d  = buf_data_q[nxt_c];
                        out_index_d = buf_idx_q[nxt_c];
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            stage_q     <= '0;
            step_q      <= '0;
            pair_q      <= '0;
            cas_en_q    <= 1'b0;
            cas_o1_q    <= '0;
            cas_o2_q    <= '0;
            cas_od1_q   <= '0;
            cas_od2_q   <= '0;
            for (int n = 0; n < N_INPUTS; n++) begin
                buf_data_q[n] <= '0;
                buf_idx_q[n]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            stage_q     <= stage_d;
            step_q      <= step_d;
            pair_q      <= pair_d;
            cas_en_q    <= cas_en_d;
            cas_o1_q    <= cas_o1_d;
            cas_o2_q    <= cas_o2_d;
            cas_od1_q   <= cas_od1_d;
            cas_od2_q   <= cas_od2_d;
            buf_data_q  <= buf_data_d;
            buf_idx_q   <= buf_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_bitonic_cas_sequencer.sv
// Bench for bitonic_cas_sequencer: directed cases plus random sets checked
// against an array-based bitonic reference model.
module tb_bitonic_cas_sequencer;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int IW = 3;

    typedef logic [DW-1:0] key_t [N];
    typedef logic [IW-1:0] idx_t [N];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sort_dir = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          busy;

    int n_total = 0;
    int n_bad   = 0;

    key_t rx_d;
    idx_t rx_i;

    bitonic_cas_sequencer #(
        .DATA_WIDTH (DW),
        .N_INPUTS   (N),
        .INDEX_WIDTH(IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sort_dir (sort_dir),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the bitonic schedule applied directly to arrays.
    function automatic void model_sort(input key_t keys, input logic dir,
                                       output key_t od, output idx_t oi);
        for (int i = 0; i < N; i++) begin
            od[i] = keys[i];
            oi[i] = IW'(i);
        end
        for (int k = 2; k <= N; k *= 2) begin
            for (int j = k / 2; j >= 1; j /= 2) begin
                for (int i = 0; i < N; i++) begin
                    int  p;
                    logic up, sw;
                    logic [DW-1:0] td;
                    logic [IW-1:0] ti;
                    p = i ^ j;
                    if (p > i) begin
                        up = ((i & k) == 0) ? dir : !dir;
                        sw = up ? (od[i] > od[p]) : (od[i] <= od[p]);
                        if (sw) begin
                            td = od[i]; od[i] = od[p]; od[p] = td;
                            ti = oi[i]; oi[i] = oi[p]; oi[p] = ti;
                        end
                    end
                end
            end
        end
    endfunction

    // Present one set; sort_dir is only correct on beat 0 to show it is latched there.
    task automatic send_set(input key_t keys, input logic dir);
        for (int k = 0; k < N; k++) begin
            int g = 0;
            in_valid = 1'b1;
            in_data  = keys[k];
            sort_dir = (k == 0) ? dir : !dir;
            while (!in_ready && g < 300) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready) check_eq("in_ready_wait", 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Collect N outputs. pat: 0 always ready, 1 ready 1,0,0 repeating, 2 random.
    task automatic drain(input int pat, output int lat, output int bcnt);
        int got = 0, cyc = 0, dc = 0;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic [IW-1:0] prev_i = '0;
        lat  = -1;
        bcnt = 0;
        while (got < N && cyc < 2000) begin
            if (busy) bcnt++;
            if (out_valid && lat < 0) lat = cyc;
            if (!out_valid) out_ready = 1'b1;
            else if (pat == 0) out_ready = 1'b1;
            else if (pat == 1) out_ready = ((dc % 3) == 0);
            else out_ready = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                check_eq("stall_data", 64'(out_data), 64'(prev_d));
                check_eq("stall_index", 64'(out_index), 64'(prev_i));
            end
            prev_stall = 1'b0;
            if (out_valid) begin
                check_eq("in_ready_in_drain", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    rx_d[got] = out_data;
                    rx_i[got] = out_index;
                    got++;
                end else begin
                    prev_stall = 1'b1;
                    prev_d = out_data;
                    prev_i = out_index;
                end
                dc++;
            end
            @(negedge clk);
            cyc++;
        end
        if (got < N) check_eq("drain_timeout", 64'(got), 64'(N));
        out_ready = 1'b1;
        check_eq("after_drain_out_valid", 64'(out_valid), 64'd0);
        check_eq("after_drain_in_ready", 64'(in_ready), 64'd1);
        check_eq("after_drain_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_set(input string tag, input key_t ed, input idx_t ei);
        for (int p = 0; p < N; p++) begin
            check_eq($sformatf("%s_data%0d", tag, p), 64'(rx_d[p]), 64'(ed[p]));
            check_eq($sformatf("%s_index%0d", tag, p), 64'(rx_i[p]), 64'(ei[p]));
        end
    endtask

    task automatic check_perm(input string tag);
        logic [N-1:0] seen = '0;
        for (int p = 0; p < N; p++) seen[rx_i[p]] = 1'b1;
        check_eq({tag, "_perm"}, 64'(seen), {{(64-N){1'b0}}, {N{1'b1}}});
    endtask

    initial begin
        key_t k_base, k_dup, k_alt, keys, md, asc_d, dsc_d, dup_d;
        idx_t asc_i, dsc_i, mi;
        int lat, bcnt;
        logic seen_out, dir;

        k_base = '{32'd5, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
        asc_d  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        asc_i  = '{3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2, 3'd4};
        dsc_d  = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        dsc_i  = '{3'd4, 3'd2, 3'd6, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3};
        k_dup  = '{32'd0, 32'hFFFFFFFF, 32'd0, 32'd7, 32'd7, 32'd1, 32'hFFFFFFFF, 32'd0};
        dup_d  = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        k_alt  = '{32'd40, 32'd10, 32'd70, 32'd20, 32'd0, 32'd90, 32'd30, 32'd60};

        // 1: reset
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_in_ready", 64'(in_ready), 64'd0);
            check_eq("rst_out_valid", 64'(out_valid), 64'd0);
            check_eq("rst_busy", 64'(busy), 64'd0);
            check_eq("rst_out_data", 64'(out_data), 64'd0);
            check_eq("rst_out_index", 64'(out_index), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("post_rst_busy", 64'(busy), 64'd0);

        // 2: ascending with latency and busy span
        send_set(k_base, 1'b1);
        drain(0, lat, bcnt);
        check_set("asc", asc_d, asc_i);
        check_eq("asc_latency", 64'(lat), 64'd48);
        check_eq("asc_busy_cycles", 64'(bcnt), 64'd56);

        // 3: descending
        send_set(k_base, 1'b0);
        drain(0, lat, bcnt);
        check_set("dsc", dsc_d, dsc_i);

        // 4: backpressure during drain
        send_set(k_base, 1'b1);
        drain(1, lat, bcnt);
        check_set("bp", asc_d, asc_i);

        // 5: reset 20 cycles into SORT discards the set
        send_set(k_base, 1'b1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        seen_out = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen_out = 1'b1;
        end
        check_eq("mid_rst_no_output", 64'(seen_out), 64'd0);
        send_set(k_alt, 1'b1);
        drain(0, lat, bcnt);
        model_sort(k_alt, 1'b1, md, mi);
        check_set("after_rst", md, mi);

        // 6: duplicates and boundary keys
        send_set(k_dup, 1'b1);
        drain(2, lat, bcnt);
        for (int p = 0; p < N; p++)
            check_eq($sformatf("dup_data%0d", p), 64'(rx_d[p]), 64'(dup_d[p]));
        check_perm("dup");

        // Random sets: narrow key range for ties, alternating with full range
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < N; i++)
                keys[i] = (s % 2 == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            dir = 1'($urandom_range(0, 1));
            send_set(keys, dir);
            drain(2, lat, bcnt);
            model_sort(keys, dir, md, mi);
            check_set($sformatf("rnd%0d", s), md, mi);
            check_perm($sformatf("rnd%0d", s));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
